mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port synchronous RAM.
// Grants are combinational with round-robin tie-break; responses follow one cycle later.
module mem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_SIZE  = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    // Bounds are 33 bits wide so a window ending at 2^32 does not wrap to zero.
    localparam logic [32:0] LO_BOUND = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_BOUND = {1'b0, BASE_ADDR} + 33'(MEM_SIZE);

    function automatic logic addr_err(input logic [31:0] addr);
        logic [32:0] wide;
        wide = {1'b0, addr};
        return (addr[1:0] != 2'b00) || (wide < LO_BOUND) || (wide >= HI_BOUND);
    endfunction

    logic        last_gnt_r;   // 0 = fetch granted last, 1 = data granted last
    logic        rsp_valid_r;
    logic        rsp_owner_r;  // 0 = fetch, 1 = data
    logic        rsp_read_r;
    logic        rsp_err_r;

    logic        gnt_any_s;
    logic        gnt_we_s;
    logic        gnt_err_s;
    logic [31:0] gnt_addr_s;

    // Arbitration: sole requester wins, ties go to the port not granted last.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_n == 1'b0) begin
            if_gnt = 1'b0;
            d_gnt  = 1'b0;
        end else if (if_req && d_req) begin
            if (last_gnt_r) begin
                if_gnt = 1'b1;
            end else begin
                d_gnt = 1'b1;
            end
        end else if (if_req) begin
            if_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else begin
            if_gnt = 1'b0;
            d_gnt  = 1'b0;
        end
    end

    // Select the attributes of whichever request is being accepted.
    always_comb begin
        gnt_any_s  = if_gnt | d_gnt;
        gnt_we_s   = 1'b0;
        gnt_addr_s = 32'h0;
        if (d_gnt) begin
            gnt_addr_s = d_addr;
            gnt_we_s   = d_we;
        end else if (if_gnt) begin
            gnt_addr_s = if_addr;
            gnt_we_s   = 1'b0;
        end else begin
            gnt_addr_s = 32'h0;
            gnt_we_s   = 1'b0;
        end
        gnt_err_s = gnt_any_s & addr_err(gnt_addr_s);
    end

    // RAM port: driven only for an accepted, in-range, aligned request.
    always_comb begin
        mem_addr = 32'h0;
        mem_we   = 1'b0;
        mem_wd   = 32'h0;
        if (gnt_any_s && !gnt_err_s) begin
            mem_addr = gnt_addr_s - BASE_ADDR;
            mem_we   = gnt_we_s;
            mem_wd   = gnt_we_s ? d_wdata : 32'h0;
        end else begin
            mem_addr = 32'h0;
            mem_we   = 1'b0;
            mem_wd   = 32'h0;
        end
    end

    // Capture response bookkeeping and round-robin history at each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_r  <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_owner_r <= 1'b0;
            rsp_read_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= gnt_any_s;
            rsp_owner_r <= d_gnt;
            rsp_read_r  <= gnt_any_s & ~gnt_we_s;
            rsp_err_r   <= gnt_err_s;
            if (gnt_any_s) begin
                last_gnt_r <= d_gnt;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
        end
    end

    // Route the response to its owner; read data passes straight from the RAM.
    always_comb begin
        if_rvalid = 1'b0;
        if_err    = 1'b0;
        if_rdata  = 32'h0;
        d_rvalid  = 1'b0;
        d_err     = 1'b0;
        d_rdata   = 32'h0;
        if (rsp_valid_r && rsp_owner_r) begin
            d_rvalid = 1'b1;
            d_err    = rsp_err_r;
            d_rdata  = (rsp_read_r && !rsp_err_r) ? mem_rd : 32'h0;
        end else if (rsp_valid_r) begin
            if_rvalid = 1'b1;
            if_err    = rsp_err_r;
            if_rdata  = (rsp_read_r && !rsp_err_r) ? mem_rd : 32'h0;
        end else begin
            if_rvalid = 1'b0;
            d_rvalid  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.BASE_ADDR(32'h8000_0000), .MEM_SIZE(65536)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: preloaded once, write-first not needed, read data one cycle later.
    logic [31:0] ram [0:16383];
    logic        ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int k = 0; k < 16384; k++) ram[k] <= 32'h0;
            ram[0]     <= 32'h0000_0013;
            ram[1]     <= 32'h1111_1111;
            ram[2]     <= 32'h2222_2222;
            ram[3]     <= 32'h3333_3333;
            ram[16383] <= 32'hABCD_0123;
            ram_loaded <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr[15:2]] <= mem_wd;
            mem_rd <= ram[mem_addr[15:2]];
        end
    end

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wd;
        logic        e_if_rv;
        logic        e_if_err;
        logic [31:0] e_if_rd;
        logic        e_d_rv;
        logic        e_d_err;
        logic [31:0] e_d_rd;
    } vec_t;

    vec_t vecs [0:20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " if_gnt"},    {31'h0, if_gnt},    {31'h0, v.e_if_gnt});
        chk({tag, " d_gnt"},     {31'h0, d_gnt},     {31'h0, v.e_d_gnt});
        chk({tag, " mem_we"},    {31'h0, mem_we},    {31'h0, v.e_mem_we});
        chk({tag, " mem_addr"},  mem_addr,           v.e_mem_addr);
        chk({tag, " mem_wd"},    mem_wd,             v.e_mem_wd);
        chk({tag, " if_rvalid"}, {31'h0, if_rvalid}, {31'h0, v.e_if_rv});
        chk({tag, " if_err"},    {31'h0, if_err},    {31'h0, v.e_if_err});
        chk({tag, " if_rdata"},  if_rdata,           v.e_if_rd);
        chk({tag, " d_rvalid"},  {31'h0, d_rvalid},  {31'h0, v.e_d_rv});
        chk({tag, " d_err"},     {31'h0, d_err},     {31'h0, v.e_d_err});
        chk({tag, " d_rdata"},   d_rdata,            v.e_d_rd);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    vec_t idle_v;

    initial begin
        // Fields: if_req if_addr d_req d_we d_addr d_wdata | if_gnt d_gnt mem_we mem_addr mem_wd |
        //         if_rv if_err if_rd | d_rv d_err d_rd. Round-robin history starts as "data last".
        vecs[0]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0013, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h8000_0004, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h8000_0004, 1'b1, 1'b0, 32'h8000_000C, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2222_2222};
        vecs[4]  = '{1'b1, 32'h8000_0008, 1'b1, 1'b0, 32'h8000_000C, 32'h0, 1'b0, 1'b1, 1'b0, 32'hC, 32'h0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h8000_0008, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_3333};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0002, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h8001_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 32'h7FFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_FFFC, 32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFC, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hABCD_0123};
        vecs[15] = '{1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h8001_0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h8001_0000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0013, 1'b0, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0};
        vecs[18] = '{1'b1, 32'h8000_0001, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[20] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1111_1111};
        idle_v   = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};

        // Reset held with both ports requesting: nothing may be granted or driven.
        rst_n = 1'b0;
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        #2;
        chk_all("reset", idle_v);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req,
                  vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata);
            #2;
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted in the response cycle of a data read: the response must vanish.
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0008, 32'h0);
        #2;
        chk("midrst grant d_gnt", {31'h0, d_gnt}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0004, 32'h0);
        #2;
        chk("midrst d_rvalid", {31'h0, d_rvalid}, 32'h0);
        chk("midrst d_rdata", d_rdata, 32'h0);
        chk("midrst if_gnt", {31'h0, if_gnt}, 32'h0);
        chk("midrst d_gnt", {31'h0, d_gnt}, 32'h0);
        chk("midrst mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        #2;
        chk("midrst hold d_rvalid", {31'h0, d_rvalid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("post-rst if_gnt", {31'h0, if_gnt}, 32'h1);
        chk("post-rst d_gnt", {31'h0, d_gnt}, 32'h0);
        chk("post-rst d_rvalid", {31'h0, d_rvalid}, 32'h0);
        chk("post-rst if_rvalid", {31'h0, if_rvalid}, 32'h0);
        @(negedge clk);
        #2;
        chk("post-rst2 if_rvalid", {31'h0, if_rvalid}, 32'h1);
        chk("post-rst2 if_rdata", if_rdata, 32'h0000_0013);
        chk("post-rst2 d_gnt", {31'h0, d_gnt}, 32'h1);
        chk("post-rst2 d_rvalid", {31'h0, d_rvalid}, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("post-rst3 d_rvalid", {31'h0, d_rvalid}, 32'h1);
        chk("post-rst3 d_rdata", d_rdata, 32'h1111_1111);
        chk("post-rst3 if_rvalid", {31'h0, if_rvalid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
